vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_pix_div.sv | 45 ++++
 rtl/vga_timing_gen.sv | 133 +++++++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and shared types for the VGA raster generator
// Contents: DEF_* timing defaults (pixels / lines), coord_t (10-bit scan coordinate),
//           vphase_t (vertical phase of the frame).
package vga_pkg;

    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        VPH_ACTIVE = 2'd0,
        VPH_FRONT  = 2'd1,
        VPH_SYNC   = 2'd2,
        VPH_BACK   = 2'd3
    } vphase_t;

endpackage

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - modulo-CLK_DIV divider producing the pixel strobe and pixel clock
// Ports: i_clk (system clock), i_rst_n (async active-low reset),
//        o_pix_en (one-clock strobe, high while divider = CLK_DIV-1),
//        o_pixel_clk (high for the second half of each pixel period).
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_pix_en,
    output logic o_pixel_clk
);

    localparam int             W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0]   C_LAST = W'(CLK_DIV - 1);
    localparam logic [W-1:0]   C_HALF = W'(CLK_DIV / 2);
    localparam logic [W-1:0]   C_ONE  = W'(1);

    logic [W-1:0] r_div;
    logic [W-1:0] w_div_nxt;
    logic         r_pix_en;
    logic         r_pixel_clk;

    always_comb begin
        w_div_nxt = (r_div == C_LAST) ? '0 : r_div + C_ONE;
    end

    // Strobe and clock are decoded from the next divider value so they line
    // up with the divider register itself rather than lagging one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div       <= '0;
            r_pix_en    <= 1'b0;
            r_pixel_clk <= 1'b0;
        end else begin
            r_div       <= w_div_nxt;
            r_pix_en    <= (w_div_nxt == C_LAST);
            r_pixel_clk <= (w_div_nxt >= C_HALF);
        end
    end

    assign o_pix_en    = r_pix_en;
    assign o_pixel_clk = r_pixel_clk;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, syncs, blank, frame tick)
// Ports: Clk, Reset_n (async active-low); pixel_clk, pix_en from the divider;
//        hs, vs (active-low syncs); blank (1 = visible); DrawX, DrawY (raw scan counts);
//        frame_tick (one-clock pulse at start of vertical blanking, only with VGA_FRAME_TICK_EN).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic   Clk,
    input  logic   Reset_n,
    output logic   pixel_clk,
    output logic   pix_en,
    output logic   hs,
    output logic   vs,
    output logic   blank,
    output coord_t DrawX,
    output coord_t DrawY
`ifdef VGA_FRAME_TICK_EN
    ,
    output logic   frame_tick
`endif
);

    localparam int     H_TOTAL       = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL       = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t C_X_LAST      = coord_t'(H_TOTAL - 1);
    localparam coord_t C_Y_LAST      = coord_t'(V_TOTAL - 1);
    localparam coord_t C_X_VIS       = coord_t'(H_VISIBLE);
    localparam coord_t C_Y_VIS       = coord_t'(V_VISIBLE);
    localparam coord_t C_HS_FIRST    = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t C_HS_LAST     = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t C_Y_ACT_LAST  = coord_t'(V_VISIBLE - 1);
    localparam coord_t C_Y_FP_LAST   = coord_t'(V_VISIBLE + V_FP - 1);
    localparam coord_t C_Y_SYNC_LAST = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic    w_pix_en;
    logic    w_pixel_clk;
    logic    w_line_wrap;
    coord_t  w_x_nxt;
    coord_t  w_y_nxt;
    vphase_t w_phase_nxt;

    coord_t  r_x;
    coord_t  r_y;
    vphase_t r_phase;
    logic    r_hs;
    logic    r_vs;
    logic    r_blank;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .i_clk       (Clk),
        .i_rst_n     (Reset_n),
        .o_pix_en    (w_pix_en),
        .o_pixel_clk (w_pixel_clk)
    );

    always_comb begin
        w_line_wrap = w_pix_en && (r_x == C_X_LAST);
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_phase_nxt = r_phase;
        if (w_pix_en) begin
            w_x_nxt = w_line_wrap ? '0 : r_x + 10'd1;
        end
        // Vertical state only moves on the pixel that ends a line.
        if (w_line_wrap) begin
            w_y_nxt = (r_y == C_Y_LAST) ? '0 : r_y + 10'd1;
            case (r_phase)
                VPH_ACTIVE: if (r_y == C_Y_ACT_LAST)  w_phase_nxt = VPH_FRONT;
                VPH_FRONT:  if (r_y == C_Y_FP_LAST)   w_phase_nxt = VPH_SYNC;
                VPH_SYNC:   if (r_y == C_Y_SYNC_LAST) w_phase_nxt = VPH_BACK;
                VPH_BACK:   if (r_y == C_Y_LAST)      w_phase_nxt = VPH_ACTIVE;
                default:                              w_phase_nxt = VPH_ACTIVE;
            endcase
        end
    end

`ifdef VGA_FRAME_TICK_EN
    logic w_frame_start;
    logic r_frame_tick;

    assign w_frame_start = w_line_wrap && (r_phase == VPH_ACTIVE) && (r_y == C_Y_ACT_LAST);
`endif

    // Syncs and blank are decoded from the next-state counters so they change
    // on the same edge as DrawX/DrawY.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_phase      <= VPH_ACTIVE;
            r_hs         <= 1'b1;
            r_vs         <= 1'b1;
            r_blank      <= 1'b1;
`ifdef VGA_FRAME_TICK_EN
            r_frame_tick <= 1'b0;
`endif
        end else begin
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_phase      <= w_phase_nxt;
            r_hs         <= !((w_x_nxt >= C_HS_FIRST) && (w_x_nxt <= C_HS_LAST));
            r_vs         <= (w_phase_nxt != VPH_SYNC);
            r_blank      <= (w_x_nxt < C_X_VIS) && (w_y_nxt < C_Y_VIS);
`ifdef VGA_FRAME_TICK_EN
            r_frame_tick <= w_frame_start;
`endif
        end
    end

    assign pixel_clk = w_pixel_clk;
    assign pix_en    = w_pix_en;
    assign hs        = r_hs;
    assign vs        = r_vs;
    assign blank     = r_blank;
    assign DrawX     = r_x;
    assign DrawY     = r_y;
`ifdef VGA_FRAME_TICK_EN
    assign frame_tick = r_frame_tick;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen (default, CLK_DIV=4 and reduced-raster instances)
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic   Clk;
    logic   Reset_n;

    logic   d_pclk, d_pix_en, d_hs, d_vs, d_blank;
    coord_t d_x, d_y;
    logic   f_pclk, f_pix_en, f_hs, f_vs, f_blank;
    coord_t f_x, f_y;
    logic   s_pclk, s_pix_en, s_hs, s_vs, s_blank;
    coord_t s_x, s_y;
`ifdef VGA_FRAME_TICK_EN
    logic   d_tick, f_tick, s_tick;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Standard 640x480 timing, CLK_DIV = 2.
    vga_timing_gen #(.CLK_DIV(2)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(d_pclk), .pix_en(d_pix_en),
        .hs(d_hs), .vs(d_vs), .blank(d_blank), .DrawX(d_x), .DrawY(d_y)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(d_tick)
`endif
    );

    // Standard timing, CLK_DIV = 4.
    vga_timing_gen #(.CLK_DIV(4)) u_div4 (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(f_pclk), .pix_en(f_pix_en),
        .hs(f_hs), .vs(f_vs), .blank(f_blank), .DrawX(f_x), .DrawY(f_y)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(f_tick)
`endif
    );

    // Reduced raster: 16 x 10 total, hs low x 10..12, vs low y 6..7, 320 Clk per frame.
    vga_timing_gen #(
        .CLK_DIV(2),
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .pixel_clk(s_pclk), .pix_en(s_pix_en),
        .hs(s_hs), .vs(s_vs), .blank(s_blank), .DrawX(s_x), .DrawY(s_y)
`ifdef VGA_FRAME_TICK_EN
        , .frame_tick(s_tick)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released,
    // so the next rising edge is edge 1.
    task automatic do_reset();
        Reset_n = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        step();
        step();
        total_cnt++; if (d_x !== 10'd0) $display("FAIL reset_drawx: got %0d expected 0", d_x); else pass_cnt++;
        total_cnt++; if (d_y !== 10'd0) $display("FAIL reset_drawy: got %0d expected 0", d_y); else pass_cnt++;
        total_cnt++; if (d_hs !== 1'b1) $display("FAIL reset_hs: got %b expected 1", d_hs); else pass_cnt++;
        total_cnt++; if (d_vs !== 1'b1) $display("FAIL reset_vs: got %b expected 1", d_vs); else pass_cnt++;
        total_cnt++; if (d_blank !== 1'b1) $display("FAIL reset_blank: got %b expected 1", d_blank); else pass_cnt++;
        total_cnt++; if (d_pix_en !== 1'b0) $display("FAIL reset_pix_en: got %b expected 0", d_pix_en); else pass_cnt++;
        total_cnt++; if (d_pclk !== 1'b0) $display("FAIL reset_pixel_clk: got %b expected 0", d_pclk); else pass_cnt++;
    endtask

    task automatic test_first_pixel();
        do_reset();
        step();
        total_cnt++; if (d_pix_en !== 1'b1) $display("FAIL edge1_pix_en: got %b expected 1", d_pix_en); else pass_cnt++;
        total_cnt++; if (d_x !== 10'd0) $display("FAIL edge1_drawx: got %0d expected 0", d_x); else pass_cnt++;
        total_cnt++; if (d_pclk !== 1'b1) $display("FAIL edge1_pixel_clk: got %b expected 1", d_pclk); else pass_cnt++;
        step();
        total_cnt++; if (d_x !== 10'd1) $display("FAIL edge2_drawx: got %0d expected 1", d_x); else pass_cnt++;
        total_cnt++; if (d_y !== 10'd0) $display("FAIL edge2_drawy: got %0d expected 0", d_y); else pass_cnt++;
        total_cnt++; if (d_pix_en !== 1'b0) $display("FAIL edge2_pix_en: got %b expected 0", d_pix_en); else pass_cnt++;
        total_cnt++; if (d_blank !== 1'b1) $display("FAIL edge2_blank: got %b expected 1", d_blank); else pass_cnt++;
        total_cnt++; if ((d_hs !== 1'b1) || (d_vs !== 1'b1)) $display("FAIL edge2_syncs: got hs=%b vs=%b expected 1 1", d_hs, d_vs); else pass_cnt++;
    endtask

    task automatic test_line();
        int hs_cnt     = 0;
        int hs_first   = -1;
        int blank_fall = -1;
        int wrap_edge  = -1;
        int wrap_x     = -1;
        int prev_x     = -1;
        do_reset();
        for (int n = 1; n <= 2000; n++) begin
            step();
            if (d_y == 10'd1) begin
                wrap_edge = n;
                wrap_x    = int'(d_x);
                break;
            end
            if (d_hs === 1'b0) begin
                if (hs_first < 0) hs_first = int'(d_x);
                hs_cnt++;
            end
            if ((d_blank === 1'b0) && (blank_fall < 0)) blank_fall = int'(d_x);
            prev_x = int'(d_x);
        end
        total_cnt++; if (wrap_edge != 1600) $display("FAIL line_wrap_edge: got %0d expected 1600", wrap_edge); else pass_cnt++;
        total_cnt++; if (prev_x != 799) $display("FAIL line_last_x: got %0d expected 799", prev_x); else pass_cnt++;
        total_cnt++; if (wrap_x != 0) $display("FAIL line_wrap_x: got %0d expected 0", wrap_x); else pass_cnt++;
        total_cnt++; if (hs_cnt != 192) $display("FAIL line_hs_width_clk: got %0d expected 192", hs_cnt); else pass_cnt++;
        total_cnt++; if (hs_first != 656) $display("FAIL line_hs_start_x: got %0d expected 656", hs_first); else pass_cnt++;
        total_cnt++; if (blank_fall != 640) $display("FAIL line_blank_fall_x: got %0d expected 640", blank_fall); else pass_cnt++;
        total_cnt++; if ((d_blank !== 1'b1) || (d_hs !== 1'b1)) $display("FAIL line_wrap_flags: got blank=%b hs=%b expected 1 1", d_blank, d_hs); else pass_cnt++;
    endtask

    task automatic test_clk_div4();
        int first_pe  = -1;
        int x1_edge   = -1;
        int wrap_edge = -1;
        int pe_cnt    = 0;
        int pc_cnt    = 0;
        int hs_cnt    = 0;
        int hs_first  = -1;
        do_reset();
        for (int n = 1; n <= 4000; n++) begin
            step();
            if ((f_x == 10'd1) && (x1_edge < 0)) x1_edge = n;
            if (f_y == 10'd1) begin
                wrap_edge = n;
                break;
            end
            if (f_pix_en === 1'b1) begin
                if (first_pe < 0) first_pe = n;
                pe_cnt++;
            end
            if (f_pclk === 1'b1) pc_cnt++;
            if (f_hs === 1'b0) begin
                if (hs_first < 0) hs_first = int'(f_x);
                hs_cnt++;
            end
        end
        total_cnt++; if (first_pe != 3) $display("FAIL div4_first_pix_en_edge: got %0d expected 3", first_pe); else pass_cnt++;
        total_cnt++; if (x1_edge != 4) $display("FAIL div4_drawx1_edge: got %0d expected 4", x1_edge); else pass_cnt++;
        total_cnt++; if (wrap_edge != 3200) $display("FAIL div4_line_edge: got %0d expected 3200", wrap_edge); else pass_cnt++;
        total_cnt++; if (pe_cnt != 800) $display("FAIL div4_pix_en_count: got %0d expected 800", pe_cnt); else pass_cnt++;
        total_cnt++; if (pc_cnt != 1600) $display("FAIL div4_pixel_clk_high: got %0d expected 1600", pc_cnt); else pass_cnt++;
        total_cnt++; if (hs_cnt != 384) $display("FAIL div4_hs_width_clk: got %0d expected 384", hs_cnt); else pass_cnt++;
        total_cnt++; if (hs_first != 656) $display("FAIL div4_hs_start_x: got %0d expected 656", hs_first); else pass_cnt++;
    endtask

    task automatic test_frame();
        int ret_edge   = -1;
        int prev_x     = -1;
        int prev_y     = -1;
        int vs_cnt     = 0;
        int vs_first_y = -1;
        int vs_first_x = -1;
        do_reset();
        for (int n = 1; n <= 1000; n++) begin
            step();
            if ((n > 2) && (s_x == 10'd0) && (s_y == 10'd0)) begin
                ret_edge = n;
                break;
            end
            if (s_vs === 1'b0) begin
                if (vs_first_y < 0) begin
                    vs_first_y = int'(s_y);
                    vs_first_x = int'(s_x);
                end
                vs_cnt++;
            end
            prev_x = int'(s_x);
            prev_y = int'(s_y);
        end
        total_cnt++; if (ret_edge != 320) $display("FAIL frame_return_edge: got %0d expected 320", ret_edge); else pass_cnt++;
        total_cnt++; if ((prev_x != 15) || (prev_y != 9)) $display("FAIL frame_last_xy: got %0d,%0d expected 15,9", prev_x, prev_y); else pass_cnt++;
        total_cnt++; if (vs_cnt != 64) $display("FAIL frame_vs_width_clk: got %0d expected 64", vs_cnt); else pass_cnt++;
        total_cnt++; if ((vs_first_y != 6) || (vs_first_x != 0)) $display("FAIL frame_vs_start: got y=%0d x=%0d expected 6 0", vs_first_y, vs_first_x); else pass_cnt++;
        total_cnt++; if ((s_hs !== 1'b1) || (s_vs !== 1'b1) || (s_blank !== 1'b1)) $display("FAIL double_wrap_flags: got hs=%b vs=%b blank=%b expected 1 1 1", s_hs, s_vs, s_blank); else pass_cnt++;
    endtask

`ifdef VGA_FRAME_TICK_EN
    task automatic test_frame_tick();
        int   tick_cnt  = 0;
        int   t1        = -1;
        int   t3        = -1;
        int   y1        = -1;
        int   x1        = -1;
        int   consec    = 0;
        logic prev_tick = 1'b0;
        do_reset();
        for (int n = 1; n <= 1000; n++) begin
            step();
            if (s_tick === 1'b1) begin
                tick_cnt++;
                if (prev_tick === 1'b1) consec++;
                if (tick_cnt == 1) begin
                    t1 = n;
                    y1 = int'(s_y);
                    x1 = int'(s_x);
                end
                if (tick_cnt == 3) t3 = n;
            end
            prev_tick = s_tick;
        end
        total_cnt++; if (tick_cnt != 3) $display("FAIL tick_count: got %0d expected 3", tick_cnt); else pass_cnt++;
        total_cnt++; if (t1 != 128) $display("FAIL tick_first_edge: got %0d expected 128", t1); else pass_cnt++;
        total_cnt++; if ((y1 != 4) || (x1 != 0)) $display("FAIL tick_position: got y=%0d x=%0d expected 4 0", y1, x1); else pass_cnt++;
        total_cnt++; if (t3 - t1 != 640) $display("FAIL tick_spacing: got %0d expected 640", t3 - t1); else pass_cnt++;
        total_cnt++; if (consec != 0) $display("FAIL tick_width: got %0d extra cycles expected 0", consec); else pass_cnt++;
    endtask
`endif

    task automatic test_async_reset();
        int found = -1;
        do_reset();
        for (int n = 1; n <= 400; n++) begin
            step();
            if ((s_vs === 1'b0) && (s_hs === 1'b0)) begin
                found = n;
                break;
            end
        end
        total_cnt++; if (found != 212) $display("FAIL async_setup_edge: got %0d expected 212", found); else pass_cnt++;
        // Assert reset mid-cycle, well clear of any rising edge.
        #2;
        Reset_n = 1'b0;
        #1;
        total_cnt++; if ((s_hs !== 1'b1) || (s_vs !== 1'b1)) $display("FAIL async_syncs: got hs=%b vs=%b expected 1 1", s_hs, s_vs); else pass_cnt++;
        total_cnt++; if (s_blank !== 1'b1) $display("FAIL async_blank: got %b expected 1", s_blank); else pass_cnt++;
        total_cnt++; if ((s_x !== 10'd0) || (s_y !== 10'd0)) $display("FAIL async_counters: got %0d,%0d expected 0,0", s_x, s_y); else pass_cnt++;
        total_cnt++; if ((s_pix_en !== 1'b0) || (s_pclk !== 1'b0)) $display("FAIL async_divider: got pix_en=%b pixel_clk=%b expected 0 0", s_pix_en, s_pclk); else pass_cnt++;
        step();
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0;
        test_reset();
        test_first_pixel();
        test_line();
        test_clk_div4();
        test_frame();
`ifdef VGA_FRAME_TICK_EN
        test_frame_tick();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
